// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC iteration sequencer: state encoding,
// default iteration count / index width and mode encodings.
package cordic_pkg;

  localparam int unsigned N_ITER_DEF = 16;
  localparam int unsigned IW_DEF     = 5;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/cordic_iter_cnt.sv
// Iteration index counter: clear has priority over enable; tc_o flags the
// last micro-rotation (cnt == N_ITER-1).
module cordic_iter_cnt
  import cordic_pkg::*;
#(
  parameter int unsigned N_ITER = N_ITER_DEF,
  parameter int unsigned IW     = IW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [IW-1:0] cnt_o,
  output logic          tc_o
);

  localparam logic [IW-1:0] LAST = IW'(N_ITER - 1);

  logic [IW-1:0] cnt_q;
  logic [IW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + IW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST);

endmodule

// File: rtl/cordic_iter_ctrl.sv
// CORDIC iteration sequencer: IDLE -> LOAD -> ITER x N_ITER -> DONE handshake.
// Define CORDIC_ITER_CTRL_ABORT_EN to add an abort input for LOAD/ITER.
module cordic_iter_ctrl
  import cordic_pkg::*;
#(
  parameter int unsigned N_ITER = N_ITER_DEF,
  parameter int unsigned IW     = IW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
`ifdef CORDIC_ITER_CTRL_ABORT_EN
  input  logic          abort,
`endif
  output logic          in_ready,
  output logic          ld,
  output logic          sel_init,
  output logic [IW-1:0] iter,
  output logic          mode_q,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready
);

  state_e state_q, state_d;
  logic   mode_cap_q, mode_cap_d;
  logic   cnt_clr, cnt_en, cnt_tc;

  cordic_iter_cnt #(
    .N_ITER (N_ITER),
    .IW     (IW)
  ) u_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (iter),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    mode_cap_d = mode_cap_q;
    cnt_clr    = 1'b1;
    cnt_en     = 1'b0;
    in_ready   = 1'b0;
    ld         = 1'b0;
    sel_init   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (start) begin
          state_d    = ST_LOAD;
          mode_cap_d = mode;
        end
      end
      ST_LOAD: begin
        ld       = 1'b1;
        sel_init = 1'b1;
        busy     = 1'b1;
        state_d  = ST_ITER;
      end
      ST_ITER: begin
        ld      = 1'b1;
        busy    = 1'b1;
        // counter self-clears on the terminal count so iter is 0 in DONE
        cnt_clr = cnt_tc;
        cnt_en  = 1'b1;
        if (cnt_tc) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef CORDIC_ITER_CTRL_ABORT_EN
    if (abort && (state_q == ST_LOAD || state_q == ST_ITER)) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_cap_q <= MODE_ROT;
    end else begin
      state_q    <= state_d;
      mode_cap_q <= mode_cap_d;
    end
  end

  assign mode_q = mode_cap_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Bench for cordic_iter_ctrl: table vectors, directed corner sequences and
// random traffic on N_ITER=16 and N_ITER=1 instances against a timeline model.
module tb_cordic_iter_ctrl;

  localparam int NA = 16;
  localparam int NB = 1;
  localparam int IW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, mode, out_ready, abort;
  logic in_ready_w [2];
  logic ld_w       [2];
  logic sel_init_w [2];
  logic [IW-1:0] iter_w [2];
  logic mode_q_w   [2];
  logic busy_w     [2];
  logic out_valid_w[2];

  cordic_iter_ctrl #(.N_ITER(NA), .IW(IW)) dut_a (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
`ifdef CORDIC_ITER_CTRL_ABORT_EN
    .abort(abort),
`endif
    .in_ready(in_ready_w[0]), .ld(ld_w[0]), .sel_init(sel_init_w[0]),
    .iter(iter_w[0]), .mode_q(mode_q_w[0]), .busy(busy_w[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready)
  );

  cordic_iter_ctrl #(.N_ITER(NB), .IW(IW)) dut_b (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
`ifdef CORDIC_ITER_CTRL_ABORT_EN
    .abort(abort),
`endif
    .in_ready(in_ready_w[1]), .ld(ld_w[1]), .sel_init(sel_init_w[1]),
    .iter(iter_w[1]), .mode_q(mode_q_w[1]), .busy(busy_w[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;

  // Model: pos = clock edges since the accepting edge (0 = idle).
  // pos 1 = load cycle, 2..N+1 = iterations 0..N-1, N+2 = result waiting.
  int   pos [2] = '{0, 0};
  int   nit [2] = '{NA, NB};
  logic mq  [2] = '{1'b0, 1'b0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    logic ab;
`ifdef CORDIC_ITER_CTRL_ABORT_EN
    ab = abort;
`else
    ab = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        pos[i] = 0;
        mq[i]  = 1'b0;
      end else if (ab && pos[i] >= 1 && pos[i] <= nit[i] + 1) begin
        pos[i] = 0;
      end else if (pos[i] == 0) begin
        if (start) begin
          pos[i] = 1;
          mq[i]  = mode;
          if (i == 0) acc_cyc = cyc + 1;
        end
      end else if (pos[i] <= nit[i] + 1) begin
        pos[i] = pos[i] + 1;
      end else if (out_ready) begin
        pos[i] = 0;
      end
    end
  endtask

  task automatic compare_model();
    for (int i = 0; i < 2; i++) begin
      int  p, n, eit;
      logic active;
      p = pos[i];
      n = nit[i];
      active = (p >= 1 && p <= n + 1);
      eit = (p >= 2 && p <= n + 1) ? p - 2 : 0;
      chk($sformatf("d%0d.in_ready", i), 32'(in_ready_w[i]), 32'(p == 0));
      chk($sformatf("d%0d.ld", i), 32'(ld_w[i]), 32'(active));
      chk($sformatf("d%0d.sel_init", i), 32'(sel_init_w[i]), 32'(p == 1));
      chk($sformatf("d%0d.busy", i), 32'(busy_w[i]), 32'(active));
      chk($sformatf("d%0d.out_valid", i), 32'(out_valid_w[i]), 32'(p == n + 2));
      chk($sformatf("d%0d.iter", i), 32'(iter_w[i]), 32'(eit));
      chk($sformatf("d%0d.mode_q", i), 32'(mode_q_w[i]), 32'(mq[i]));
    end
  endtask

  task automatic step(input logic r, input logic s, input logic m,
                      input logic o, input logic a);
    rst = r; start = s; mode = m; out_ready = o; abort = a;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    compare_model();
  endtask

  typedef struct {
    logic r, s, m, o;
    logic ir, l, si;
    int   it;
    logic bz, ov, mqv;
  } vec_t;

  vec_t tbl [8];
  int   cnt;
  bit   seen;

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; out_ready = 1'b0; abort = 1'b0;

    //           r  s  m  o   ir l  si it bz ov mq
    tbl[0] = '{1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 1, 0,  1, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{0, 1, 1, 0,  0, 1, 1, 0, 1, 0, 1};
    tbl[5] = '{0, 0, 0, 0,  0, 1, 0, 0, 1, 0, 1};
    tbl[6] = '{0, 1, 0, 1,  0, 1, 0, 1, 1, 0, 1};
    tbl[7] = '{0, 0, 0, 0,  0, 1, 0, 2, 1, 0, 1};
    for (int k = 0; k < 8; k++) begin
      step(tbl[k].r, tbl[k].s, tbl[k].m, tbl[k].o, 1'b0);
      chk($sformatf("tbl%0d.in_ready", k), 32'(in_ready_w[0]), 32'(tbl[k].ir));
      chk($sformatf("tbl%0d.ld", k), 32'(ld_w[0]), 32'(tbl[k].l));
      chk($sformatf("tbl%0d.sel_init", k), 32'(sel_init_w[0]), 32'(tbl[k].si));
      chk($sformatf("tbl%0d.iter", k), 32'(iter_w[0]), 32'(tbl[k].it));
      chk($sformatf("tbl%0d.busy", k), 32'(busy_w[0]), 32'(tbl[k].bz));
      chk($sformatf("tbl%0d.out_valid", k), 32'(out_valid_w[0]), 32'(tbl[k].ov));
      chk($sformatf("tbl%0d.mode_q", k), 32'(mode_q_w[0]), 32'(tbl[k].mqv));
    end

    // Run to completion, pulsing an ignored start at iter=7.
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(1'b0, (iter_w[0] == IW'(7)), 1'b0, 1'b0, 1'b0);
      seen = out_valid_w[0];
    end
    chk("done_reached", 32'(seen), 32'd1);
    // out_valid first visible after edge k+N+1, i.e. in cycle k+N+2
    chk("latency_edges", 32'(cyc - acc_cyc), 32'(NA + 1));
    chk("mode_q_held", 32'(mode_q_w[0]), 32'd1);

    // Stall the result for 5 cycles, then accept it.
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (out_valid_w[0] && !ld_w[0] && !in_ready_w[0]) cnt++;
    end
    chk("stall_valid_cycles", 32'(cnt), 32'd5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("idle_after_ready", 32'(in_ready_w[0]), 32'd1);

    // start held continuously through a whole operation and its DONE.
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      seen = out_valid_w[0];
    end
    chk("held_start_done", 32'(seen), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("held_start_not_in_done", 32'(in_ready_w[0]), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("held_start_accepted", 32'(sel_init_w[0]), 32'd1);

    // Reset in the middle of iterations.
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      seen = (iter_w[0] == IW'(9)) && ld_w[0];
    end
    chk("reached_iter9", 32'(seen), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_iter", 32'(iter_w[0]), 32'd0);
    chk("rst_ld", 32'(ld_w[0]), 32'd0);
    chk("rst_busy", 32'(busy_w[0]), 32'd0);
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (out_valid_w[0]) cnt++;
    end
    chk("no_valid_after_rst", 32'(cnt), 32'd0);

`ifdef CORDIC_ITER_CTRL_ABORT_EN
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      seen = (iter_w[0] == IW'(4));
    end
    chk("reached_iter4", 32'(seen), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("abort_idle", 32'(in_ready_w[0]), 32'd1);
    chk("abort_ld", 32'(ld_w[0]), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (ld_w[0] && !sel_init_w[0]) cnt++;
      seen = out_valid_w[0];
    end
    chk("post_abort_iters", 32'(cnt), 32'(NA));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // Random traffic against the model.
    for (int k = 0; k < 800; k++) begin
      logic a;
`ifdef CORDIC_ITER_CTRL_ABORT_EN
      a = ($urandom_range(0, 31) == 0);
`else
      a = 1'b0;
`endif
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
           1'($urandom), ($urandom_range(0, 2) == 0), a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
